// File: rtl/mm_job_scheduler.sv
// Round-robin job scheduler that shares one matrix-multiply engine between
// NREQ requesters. It arbitrates and captures one job, then starts the engine.
// It waits for the engine's done or aborts on timeout. It returns a
// per-requester done or err pulse, and it waits for the engine's done to drop
// before it arbitrates again.
module mm_job_scheduler #(
  parameter int NREQ    = 4,
  parameter int AW      = 32,
  parameter int TIMEOUT = 1024,
  parameter int TW      = 16,
  parameter int CW      = 16,
  localparam int OW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NREQ-1:0]    i_req,
  input  logic [NREQ*AW-1:0] i_addr,
  input  logic [NREQ-1:0]    i_mode,
  output logic [NREQ-1:0]    o_ack,
  output logic [NREQ-1:0]    o_done,
  output logic [NREQ-1:0]    o_err,
  output logic               o_mm_start,
  output logic [AW-1:0]      o_mm_addr,
  output logic               o_mm_mode,
  input  logic               i_mm_done,
  output logic               o_busy,
  output logic [OW-1:0]      o_owner,
  output logic [CW-1:0]      o_job_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_DRAIN
  } state_t;

  state_t          state_q, state_d;
  logic [OW-1:0]   rr_q, rr_d;
  logic [OW-1:0]   owner_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [CW-1:0]   cnt_d;
  logic [NREQ-1:0] ack_d, done_d, err_d;
  logic            start_d;
  logic            capture;
  logic            win_valid;
  logic [OW-1:0]   win_idx;

  // Round-robin pick: the first requester at or above rr_q, with wrap. The
  // loop runs from the farthest offset down, so the nearest request wins.
  always_comb begin
    // NOTE: every variable written here gets a default first; a missing
    // default on any path would infer a latch.
    win_valid = 1'b0;
    win_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      int slot;
      slot = int'(rr_q) + i;
      if (slot >= NREQ) slot = slot - NREQ;
      if (i_req[slot]) begin
        win_valid = 1'b1;
        win_idx   = OW'(slot);
      end
    end
  end

  // Next-state logic and the next values of the registered pulses/datapath.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = o_owner;
    timer_d = timer_q;
    cnt_d   = o_job_cnt;
    ack_d   = '0;
    done_d  = '0;
    err_d   = '0;
    start_d = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (win_valid) begin
          capture        = 1'b1;
          owner_d        = win_idx;
          ack_d[win_idx] = 1'b1;
          state_d        = S_START;
        end
      end
      S_START: begin
        // The start strobe is registered, so the engine sees it in the first
        // WAIT cycle. That cycle also has timer 0, which keeps the timeout
        // measured from the visible start.
        start_d = 1'b1;
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + TW'(1);
        if (i_mm_done) begin
          // done takes priority over a timeout that expires in the same cycle
          done_d[o_owner] = 1'b1;
          cnt_d           = o_job_cnt + CW'(1);
          state_d         = S_DRAIN;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          err_d[o_owner] = 1'b1;
          state_d        = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Hold off the next arbitration while the engine still shows the old done.
        if (!i_mm_done) begin
          rr_d    = (o_owner == OW'(NREQ - 1)) ? '0 : o_owner + OW'(1);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, pointer, timer, counter and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      rr_q       <= '0;
      timer_q    <= '0;
      o_owner    <= '0;
      o_job_cnt  <= '0;
      o_ack      <= '0;
      o_done     <= '0;
      o_err      <= '0;
      o_mm_start <= 1'b0;
      o_mm_addr  <= '0;
      o_mm_mode  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every
      // register samples the pre-edge values and ordering between them
      // cannot matter.
      state_q    <= state_d;
      rr_q       <= rr_d;
      timer_q    <= timer_d;
      o_owner    <= owner_d;
      o_job_cnt  <= cnt_d;
      o_ack      <= ack_d;
      o_done     <= done_d;
      o_err      <= err_d;
      o_mm_start <= start_d;
      if (capture) begin
        o_mm_addr <= i_addr[int'(win_idx)*AW +: AW];
        o_mm_mode <= i_mode[win_idx];
      end
    end
  end

  assign o_busy = (state_q != S_IDLE);

endmodule
